hilo_mdu: RTL and testbench



---
 rtl/hilo_mdu_pkg.sv | 29 ++
 rtl/hilo_mdu_if.sv | 27 ++
 rtl/hilo_div_step.sv | 19 +
 rtl/hilo_mdu.sv | 120 ++++++++++++
 tb/tb_hilo_mdu.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_signed(mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic op_is_div(mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// EX-stage request side and HI/LO write stream of the multiply/divide unit.
interface hilo_mdu_if
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall_req;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output flush, start, op, src_a, src_b,
    input  stall_req, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  flush, start, op, src_a, src_b,
    output stall_req, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/hilo_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH:0]   diff;

  assign rem_sh = {rem, din};
  assign q_bit  = (rem_sh >= {2'b00, divisor});
  // When the subtract is taken the result is below the divisor, so WIDTH+1 bits suffice.
  assign diff     = rem_sh[WIDTH:0] - {1'b0, divisor};
  assign rem_next = q_bit ? diff : rem_sh[WIDTH:0];
endmodule

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit; stalls EX while busy, then strikes HI/LO once.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_mdu_if.slave   bus
);
  mdu_state_e         state;
  mdu_op_e            op_q;
  logic               sgn_a_q, sgn_b_q, div0_q, we_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd, hi_q, lo_q;
  logic [WIDTH:0]     rem;

  mdu_op_e          op_in;
  logic             in_signed, in_div, last, neg_lo, neg_hi, q_bit;
  logic [WIDTH-1:0] mag_a, mag_b, quo_next, quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, rem_next;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

  assign op_in     = mdu_op_e'(bus.op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign mag_a     = (in_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b     = (in_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  assign neg_lo = op_is_signed(op_q) && (sgn_a_q ^ sgn_b_q);
  assign neg_hi = op_is_signed(op_q) && sgn_a_q;

  // Multiplier sits in the low half of acc and is consumed LSB-first as the product shifts in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign prod_fix = neg_lo ? -mul_next : mul_next;

  // Dividend sits in acc[WIDTH-1:0], MSB-first, with quotient bits shifting in behind it.
  hilo_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .din      (acc[WIDTH-1]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next = {acc[WIDTH-2:0], q_bit};
  assign quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_lo ? -quo_next : quo_next);
  assign rem_fix  = neg_hi ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      op_q    <= MDU_MULT;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      div0_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      rem     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      we_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          op_q    <= op_in;
          sgn_a_q <= bus.src_a[WIDTH-1];
          sgn_b_q <= bus.src_b[WIDTH-1];
          div0_q  <= (bus.src_b == '0);
          cnt     <= '0;
          rem     <= '0;
          acc     <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
          opnd    <= in_div ? mag_b : mag_a;
          state   <= in_div ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            hi_q  <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q  <= prod_fix[WIDTH-1:0];
            we_q  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DIV: begin
          acc <= {acc[2*WIDTH-1:WIDTH], quo_next};
          rem <= rem_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            hi_q  <= rem_fix;
            lo_q  <= quo_fix;
            we_q  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          we_q  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A flush landing on the DONE cycle must still kill that cycle's strike.
  assign bus.hi_we     = we_q && !bus.flush;
  assign bus.lo_we     = we_q && !bus.flush;
  assign bus.hi_wdata  = hi_q;
  assign bus.lo_wdata  = lo_q;
  assign bus.stall_req = ((state == ST_IDLE) && bus.start) ||
                         (state == ST_MUL) || (state == ST_DIV);
endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: driver queues expected HI/LO, negedge monitor checks strikes.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 33;  // cycles from start-seen to the DONE cycle

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc0;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0, failures = 0, cyc = 0, writes = 0, pushed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_mdu_if #(.WIDTH(W)) bus ();
  hilo_mdu #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strike must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.hi_we === 1'b1) begin
      writes++;
      check("lo_we_follows_hi_we", {63'd0, bus.lo_we}, 64'd1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got hi=%0h lo=%0h expected no write", bus.hi_wdata, bus.lo_wdata);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, {32'd0, bus.hi_wdata}, {32'd0, e.hi});
        check({e.name, "_lo"}, {32'd0, bus.lo_wdata}, {32'd0, e.lo});
        check({e.name, "_latency"}, 64'(cyc - e.cyc0), 64'(LAT));
      end
    end
  end

  task automatic begin_op(mdu_op_e op, logic [W-1:0] a, logic [W-1:0] b, bit push,
                          logic [W-1:0] eh, logic [W-1:0] el, string name);
    exp_t e;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    if (push) begin
      e.hi = eh; e.lo = el; e.cyc0 = cyc; e.name = name;
      sb.push_back(e);
      pushed++;
    end
  endtask

  task automatic finish_op(string name);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall_req) n++;
      else break;
    end
    check({name, "_stall_cycles"}, 64'(n), 64'(LAT));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run(mdu_op_e op, logic [W-1:0] a, logic [W-1:0] b,
                     logic [W-1:0] eh, logic [W-1:0] el, string name);
    begin_op(op, a, b, 1'b1, eh, el, name);
    finish_op(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.flush = 1'b0; bus.start = 1'b0; bus.op = 2'b00;
    bus.src_a = '0;   bus.src_b = '0;
    #12;
    check("rst_stall", {63'd0, bus.stall_req}, 64'd0);
    check("rst_hi_we", {63'd0, bus.hi_we}, 64'd0);
    check("rst_lo_we", {63'd0, bus.lo_we}, 64'd0);
    check("rst_hi_wdata", {32'd0, bus.hi_wdata}, 64'd0);
    check("rst_lo_wdata", {32'd0, bus.lo_wdata}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed vectors
    run(MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
    run(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
    run(MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    run(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2");
    run(MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        "divu_100d7");
    run(MDU_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, "divu_5d0");
    run(MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7d0");
    run(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

    // Flush at iteration 10, new op the following cycle
    begin_op(MDU_MULT, 32'd5, 32'd6, 1'b0, '0, '0, "flushed");
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    run(MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_flush");

    // Flush coinciding with DONE suppresses the strike
    begin_op(MDU_MULTU, 32'd9, 32'd9, 1'b0, '0, '0, "flush_done");
    repeat (LAT) @(posedge clk);
    #1 bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("flush_done_stall", {63'd0, bus.stall_req}, 64'd0);
    check("flush_done_we", {63'd0, bus.hi_we}, 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;

    // Asynchronous reset at iteration 20
    begin_op(MDU_DIVU, 32'd1000, 32'd3, 1'b0, '0, '0, "reset_mid");
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0;
    bus.start = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, bus.stall_req}, 64'd0);
    check("rst_mid_hi_we", {63'd0, bus.hi_we}, 64'd0);
    check("rst_mid_lo_we", {63'd0, bus.lo_we}, 64'd0);
    check("rst_mid_hi_wdata", {32'd0, bus.hi_wdata}, 64'd0);
    check("rst_mid_lo_wdata", {32'd0, bus.lo_wdata}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {63'd0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    run(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_reset");

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("write_count", 64'(writes), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
